branch_predict_ctrl: RTL and testbench
======================================

// Module: branch_predict_ctrl
// PURPOSE
//  Branch-direction predictor and PC-redirect/flush controller for the pipelined core.
//  Holds a table of 2-bit saturating counters indexed by PC and predicts conditional branches in ID.
//  Resolves branches in EX, using br_taken from the branch-condition unit, and drives the PC-select redirect and the pipeline flushes.
//  Trains the table and keeps branch/mispredict performance counters.
// PARAMETERS
//  IDX_BITS    6      table index width; ENTRIES = 2**IDX_BITS; index = pc[IDX_BITS+1:2]
//  INIT_STATE  2'b01  counter value loaded on reset (weakly not-taken)
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst              in   1   synchronous active-high reset
//  id_valid         in   1   ID stage holds a valid instruction
//  id_stall         in   1   ID stage frozen this cycle (hazard unit)
//  id_is_branch     in   1   ID opcode == 7'b1100011
//  id_pc            in   32  PC of the ID instruction
//  id_target        in   32  ID branch target (pc + B-imm)
//  id_pred_taken    out  1   prediction for the ID instruction; pipe it down to EX
//  ex_valid         in   1   EX stage holds a valid instruction
//  ex_is_branch     in   1   EX opcode == 7'b1100011
//  ex_is_jal        in   1   EX opcode == 7'b1101111
//  ex_br_taken      in   1   resolved taken from the branch-condition unit
//  ex_pred_taken    in   1   id_pred_taken carried with the EX instruction
//  ex_pc            in   32  PC of the EX instruction
//  ex_target        in   32  resolved EX target address
//  redirect         out  1   PC mux selects redirect_pc this cycle
//  redirect_pc      out  32  next-fetch address when redirect = 1
//  flush_if_id      out  1   bubble the IF/ID register at the next edge
//  flush_id_ex      out  1   bubble the ID/EX register at the next edge
//  perf_branches    out  32  count of resolved conditional branches
//  perf_mispredicts out  32  count of EX redirects (mispredicts + JAL)
// BEHAVIOUR
//  - Table: ENTRIES x 2-bit counters. 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken = counter[1].
//  - Reset (rst = 1 at an edge): every entry <= INIT_STATE and both perf counters <= 0.
//    While rst is high, all outputs are forced to 0, including id_pred_taken.
//  - id_pred_taken = id_valid & id_is_branch & table[id_pc idx][1]. It is combinational from registered state.
//  - ID redirect (predicted taken): id_pred_taken & ~id_stall. Drives redirect = 1, redirect_pc = id_target, flush_if_id = 1.
//    Cost is 1 bubble.
//  - EX mispredict is mis = ex_valid & ((ex_is_branch & (ex_br_taken != ex_pred_taken)) | ex_is_jal).
//    - redirect = 1, flush_if_id = 1, flush_id_ex = 1.
//    - redirect_pc = ex_target if (ex_is_jal | ex_br_taken), else ex_pc + 4 (32-bit wrap).
//  - Priority: an EX mispredict overrides a same-cycle ID redirect, because the ID instruction is wrong-path.
//    id_pred_taken itself is still reported.
//  - id_stall does not block EX redirects or flushes.
//  - Training: at the edge where ex_valid & ex_is_branch, table[ex_pc idx] is updated.
//    Taken increments it, saturating at 11. Not-taken decrements it, saturating at 00.
//    JAL does not train the table.
//  - Read/update on the same index in one cycle: ID sees the old value (no bypass). The new value is visible next cycle.
//  - perf_branches += 1 per trained branch. perf_mispredicts += 1 per EX mispredict. Both wrap at 2**32.
//  - Aliasing is permitted: PCs sharing pc[IDX_BITS+1:2] share one counter.
//  - Reset mid-operation: pending flush/redirect outputs drop the same cycle; the table reinitialises at the edge.
// TESTING
//  1. Reset, then id_valid=1, id_is_branch=1, id_pc=0x100 -> id_pred_taken=0 (WNT) and redirect=0.
//  2. Branch at 0x100 resolved taken in EX with pred=0, ex_target=0x80 -> redirect=1, redirect_pc=0x80, both flushes=1.
//     Entry becomes 10 and the next ID lookup of 0x100 gives pred=1.
//  3. Same branch predicted taken, resolved not-taken -> redirect_pc=0x104, both flushes=1. Entry drops 10->01.
//  4. Four taken resolutions -> entry saturates at 11; five not-taken -> entry saturates at 00. No wrap.
//  5. Same cycle: ID predicts taken to 0x200 and EX JAL to 0x400 -> redirect_pc=0x400 and perf_mispredicts+1.
//     With id_stall=1 and no EX event -> redirect=0.
//  6. Assert rst mid-stream with mis=1 -> all outputs 0 that cycle. Afterwards every entry reads 01 and the perf counters read 0.

Source files
------------

// File: rtl/branch_predict_if.sv
// Pipeline-side view of the branch predictor: ID lookup, EX resolution, redirect/flush
// controls and performance counters. The master is the pipeline and the slave is the predictor.
interface branch_predict_if;
  logic        id_valid;
  logic        id_stall;
  logic        id_is_branch;
  logic [31:0] id_pc;
  logic [31:0] id_target;
  logic        id_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_br_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;

  modport master (
    output id_valid, id_stall, id_is_branch, id_pc, id_target,
    output ex_valid, ex_is_branch, ex_is_jal, ex_br_taken, ex_pred_taken, ex_pc, ex_target,
    input  id_pred_taken, redirect, redirect_pc, flush_if_id, flush_id_ex,
    input  perf_branches, perf_mispredicts
  );

  modport slave (
    input  id_valid, id_stall, id_is_branch, id_pc, id_target,
    input  ex_valid, ex_is_branch, ex_is_jal, ex_br_taken, ex_pred_taken, ex_pc, ex_target,
    output id_pred_taken, redirect, redirect_pc, flush_if_id, flush_id_ex,
    output perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with ID-stage prediction, EX-stage resolution,
// PC redirect/flush control and branch/mispredict performance counters.
module branch_predict_ctrl #(
  parameter int unsigned IDX_BITS   = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input logic             clk,
  input logic             rst,
  branch_predict_if.slave bp
);
  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [1:0]          table_q [Entries];
  logic [1:0]          table_d [Entries];
  logic [31:0]         perf_br_q, perf_br_d;
  logic [31:0]         perf_mis_q, perf_mis_d;
  logic [IDX_BITS-1:0] id_idx, ex_idx;
  logic                pred, mis, train;
  logic [1:0]          cur_cnt;

  assign id_idx = bp.id_pc[IDX_BITS+1:2];
  assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign pred   = bp.id_valid & bp.id_is_branch & table_q[id_idx][1];
  assign mis    = bp.ex_valid & ((bp.ex_is_branch & (bp.ex_br_taken != bp.ex_pred_taken))
                                 | bp.ex_is_jal);
  assign train  = bp.ex_valid & bp.ex_is_branch;

  // EX mispredict wins over an ID redirect: the ID instruction is on the wrong path.
  always_comb begin
    bp.id_pred_taken    = pred;
    bp.redirect         = 1'b0;
    bp.redirect_pc      = '0;
    bp.flush_if_id      = 1'b0;
    bp.flush_id_ex      = 1'b0;
    bp.perf_branches    = perf_br_q;
    bp.perf_mispredicts = perf_mis_q;
    if (mis) begin
      bp.redirect    = 1'b1;
      bp.flush_if_id = 1'b1;
      bp.flush_id_ex = 1'b1;
      bp.redirect_pc = (bp.ex_is_jal | bp.ex_br_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
    end else if (pred & ~bp.id_stall) begin
      bp.redirect    = 1'b1;
      bp.flush_if_id = 1'b1;
      bp.redirect_pc = bp.id_target;
    end
    if (rst) begin
      bp.id_pred_taken    = 1'b0;
      bp.redirect         = 1'b0;
      bp.redirect_pc      = '0;
      bp.flush_if_id      = 1'b0;
      bp.flush_id_ex      = 1'b0;
      bp.perf_branches    = '0;
      bp.perf_mispredicts = '0;
    end
  end

  always_comb begin
    table_d    = table_q;
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    cur_cnt    = table_q[ex_idx];
    if (train) begin
      perf_br_d = perf_br_q + 32'd1;
      if (bp.ex_br_taken) begin
        if (cur_cnt != 2'b11) table_d[ex_idx] = cur_cnt + 2'b01;
      end else begin
        if (cur_cnt != 2'b00) table_d[ex_idx] = cur_cnt - 2'b01;
      end
    end
    if (mis) perf_mis_d = perf_mis_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      table_q    <= '{default: INIT_STATE};
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      table_q    <= table_d;
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: a driver pushes model-predicted outputs per cycle,
// a monitor pops and compares them against the DUT.
module tb_branch_predict_ctrl;
  localparam int IdxBits = 6;
  localparam int Entries = 1 << IdxBits;

  typedef struct {
    logic        pred;
    logic        redir;
    logic [31:0] rpc;
    logic        fif;
    logic        fie;
    logic [31:0] pb;
    logic [31:0] pm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  branch_predict_if bp_if ();

  branch_predict_ctrl #(.IDX_BITS(IdxBits), .INIT_STATE(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer counters 0..3, taken when >= 2.
  int          cnt [Entries];
  int unsigned m_pb, m_pm;
  exp_t        sb_q [$];
  int          n_vec, n_bad;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % Entries);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
    end
  endtask

  task automatic cycle(input logic r, input logic idv, input logic ids, input logic idb,
                       input logic [31:0] idpc, input logic [31:0] idtgt,
                       input logic exv, input logic exb, input logic exj, input logic ext,
                       input logic expr, input logic [31:0] expc, input logic [31:0] extgt);
    exp_t e;
    bit   mis;
    int   k;
    @(negedge clk);
    rst                 = r;
    bp_if.id_valid      = idv;
    bp_if.id_stall      = ids;
    bp_if.id_is_branch  = idb;
    bp_if.id_pc         = idpc;
    bp_if.id_target     = idtgt;
    bp_if.ex_valid      = exv;
    bp_if.ex_is_branch  = exb;
    bp_if.ex_is_jal     = exj;
    bp_if.ex_br_taken   = ext;
    bp_if.ex_pred_taken = expr;
    bp_if.ex_pc         = expc;
    bp_if.ex_target     = extgt;
    #1;
    e = '{pred: 1'b0, redir: 1'b0, rpc: 32'd0, fif: 1'b0, fie: 1'b0, pb: 32'd0, pm: 32'd0};
    if (r) begin
      sb_q.push_back(e);
      foreach (cnt[i]) cnt[i] = 1;
      m_pb = 0;
      m_pm = 0;
    end else begin
      e.pred = idv && idb && (cnt[idx_of(idpc)] >= 2);
      mis    = exv && ((exb && (ext != expr)) || exj);
      e.pb   = m_pb;
      e.pm   = m_pm;
      if (mis) begin
        e.redir = 1'b1;
        e.fif   = 1'b1;
        e.fie   = 1'b1;
        e.rpc   = (exj || ext) ? extgt : expc + 32'd4;
      end else if (e.pred && !ids) begin
        e.redir = 1'b1;
        e.fif   = 1'b1;
        e.rpc   = idtgt;
      end
      sb_q.push_back(e);
      if (exv && exb) begin
        k = idx_of(expc);
        cnt[k] = ext ? ((cnt[k] < 3) ? cnt[k] + 1 : 3) : ((cnt[k] > 0) ? cnt[k] - 1 : 0);
        m_pb++;
      end
      if (mis) m_pm++;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    cycle(0, 1, 0, 1, pc, 32'h200, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic pr,
                         input logic [31:0] tgt);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, tk, pr, pc, tgt);
  endtask

  // Monitor: pops one expectation per cycle, sampled well after the driving negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("id_pred_taken", {31'd0, bp_if.id_pred_taken}, {31'd0, e.pred});
        chk("redirect", {31'd0, bp_if.redirect}, {31'd0, e.redir});
        if (e.redir) chk("redirect_pc", bp_if.redirect_pc, e.rpc);
        chk("flush_if_id", {31'd0, bp_if.flush_if_id}, {31'd0, e.fif});
        chk("flush_id_ex", {31'd0, bp_if.flush_id_ex}, {31'd0, e.fie});
        chk("perf_branches", bp_if.perf_branches, e.pb);
        chk("perf_mispredicts", bp_if.perf_mispredicts, e.pm);
      end
    end
  end

  initial begin
    logic [31:0] pc;
    n_vec = 0;
    n_bad = 0;
    m_pb  = 0;
    m_pm  = 0;
    foreach (cnt[i]) cnt[i] = 1;
    {bp_if.id_valid, bp_if.id_stall, bp_if.id_is_branch, bp_if.ex_valid, bp_if.ex_is_branch,
     bp_if.ex_is_jal, bp_if.ex_br_taken, bp_if.ex_pred_taken} = '0;
    {bp_if.id_pc, bp_if.id_target, bp_if.ex_pc, bp_if.ex_target} = '0;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lookup(32'h100);                              // WNT -> not taken, no redirect
    resolve(32'h100, 1, 0, 32'h80);               // mispredict to 0x80, entry -> WT
    lookup(32'h100);                              // now predicts taken
    resolve(32'h100, 0, 1, 32'h80);               // redirect to 0x104, entry -> WNT
    lookup(32'h100);
    repeat (4) resolve(32'h100, 1, 1, 32'h80);    // saturate at ST
    lookup(32'h100);
    repeat (5) resolve(32'h100, 0, 0, 32'h80);    // saturate at SNT
    lookup(32'h100);
    resolve(32'h100, 1, 0, 32'h80);
    lookup(32'h100);                              // SNT+1 = WNT, still not taken
    repeat (2) resolve(32'h300, 1, 0, 32'h80);    // 0x300 trains to ST
    cycle(0, 1, 0, 1, 32'h300, 32'h200, 1, 0, 1, 0, 0, 32'h500, 32'h400); // JAL beats ID
    cycle(0, 1, 1, 1, 32'h300, 32'h200, 0, 0, 0, 0, 0, 0, 0);             // stalled ID
    cycle(0, 1, 0, 1, 32'h300, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 32'h300, 32'h200, 1, 1, 0, 1, 0, 32'h300, 32'h80);  // same-index update
    lookup(32'h300);
    cycle(1, 1, 0, 1, 32'h300, 32'h200, 1, 0, 1, 0, 0, 32'h10, 32'h40);   // reset with mis
    // Every entry must be WNT: one taken training flips each to predict-taken.
    for (int i = 0; i < Entries; i++) begin
      resolve(32'(i * 4), 1, 1, 32'h0);
      lookup(32'(i * 4));
    end
    for (int n = 0; n < 800; n++) begin
      pc = 32'($urandom_range(0, 255) * 4);
      cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
            1'($urandom), 32'($urandom_range(0, 255) * 4), $urandom);
    end
    idle();
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
